// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_responder
//  Purpose  : AXI4 slave responder backed by an internal word-addressed
//             memory. Serves one transaction at a time, INCR bursts at full
//             bus width only. Bursts wrap across the top of memory.
//  Optional : define AXI_MEM_RANGE_CHECK_EN to flag beats whose unwrapped
//             word address is >= MEM_DEPTH (writes dropped + SLVERR, reads
//             return zero data + SLVERR for that beat).
//  Ports    : clk, rst (async, active-high)
//             AW : axi_awid/awaddr/awlen/awvalid -> axi_awready
//             W  : axi_wdata/wstrb/wlast/wvalid  -> axi_wready
//             B  : axi_bid/bresp/bvalid          <- axi_bready
//             AR : axi_arid/araddr/arlen/arvalid -> axi_arready
//             R  : axi_rid/rdata/rresp/rlast/rvalid <- axi_rready
//  Revision : 1.0 - initial release
// ============================================================================
module axi_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 40,
  parameter int ID_WIDTH   = 12,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     axi_awid,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]              axi_awlen,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wlast,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ID_WIDTH-1:0]     axi_arid,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]              axi_arlen,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [ID_WIDTH-1:0]     axi_rid,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rlast,
  output logic                    axi_rvalid,
  input  logic                    axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int WA     = ADDR_WIDTH - OFF;  // word address width
  localparam int FW     = WA + 1;            // unwrapped start+beat width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [WA-1:0]         start_q, start_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic          last_w;
  logic [FW-1:0] wr_full_w;
  logic [FW-1:0] rd_full_w;
  logic          wr_oor_w;
  logic          rd_oor_w;
  logic          wr_en_w;
  logic          rd_load_w;
  logic          rd_last_next_w;
  logic          unused_w;

  assign last_w    = (beat_q == len_q);
  assign wr_full_w = {1'b0, start_q} + FW'(beat_q);
  // In IDLE the first read word comes straight from the AR bus so that
  // rvalid can rise one cycle after the handshake; later beats prefetch
  // the word after the one currently presented.
  assign rd_full_w = (state_q == IDLE) ? {1'b0, axi_araddr[ADDR_WIDTH-1:OFF]}
                                       : {1'b0, start_q} + FW'(beat_q) + FW'(1);
  assign rd_last_next_w = (state_q == IDLE) ? (axi_arlen == 8'd0)
                                            : (beat_q + 8'd1 == len_q);

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign wr_oor_w = (wr_full_w >= FW'(MEM_DEPTH));
  assign rd_oor_w = (rd_full_w >= FW'(MEM_DEPTH));
`else
  assign wr_oor_w = 1'b0;
  assign rd_oor_w = 1'b0;
`endif

  assign wr_en_w = (state_q == WR_DATA) && axi_wvalid && !wr_oor_w;

  // Sub-word address bits and the bits above the memory index are only
  // meaningful with range checking enabled.
  assign unused_w = ^{axi_awaddr[OFF-1:0], axi_araddr[OFF-1:0], wr_full_w, rd_full_w};

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    start_d   = start_q;
    err_d     = err_q;
    rd_load_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (axi_awvalid) begin
          id_d    = axi_awid;
          len_d   = axi_awlen;
          start_d = axi_awaddr[ADDR_WIDTH-1:OFF];
          beat_d  = 8'd0;
          err_d   = 1'b0;
          state_d = WR_DATA;
        end else if (axi_arvalid) begin
          id_d      = axi_arid;
          len_d     = axi_arlen;
          start_d   = axi_araddr[ADDR_WIDTH-1:OFF];
          beat_d    = 8'd0;
          rd_load_w = 1'b1;
          state_d   = RD_DATA;
        end
      end
      WR_DATA: begin
        if (axi_wvalid) begin
          // The beat count alone ends the burst; a misplaced wlast only
          // poisons the response.
          if ((axi_wlast != last_w) || wr_oor_w) begin
            err_d = 1'b1;
          end
          if (last_w) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (axi_bready) begin
          state_d = IDLE;
        end
      end
      RD_DATA: begin
        if (axi_rready) begin
          if (last_w) begin
            state_d = IDLE;
          end else begin
            beat_d    = beat_q + 8'd1;
            rd_load_w = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      start_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= 2'b00;
      rlast_q <= 1'b0;
    end else if (rd_load_w) begin
      rdata_q <= rd_oor_w ? '0 : mem[rd_full_w[IDX_W-1:0]];
      rresp_q <= rd_oor_w ? 2'b10 : 2'b00;
      rlast_q <= rd_last_next_w;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi_wstrb[i]) begin
          mem[wr_full_w[IDX_W-1:0]][i*8 +: 8] <= axi_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign axi_awready = (state_q == IDLE) && !rst;
  assign axi_arready = (state_q == IDLE) && !axi_awvalid && !rst;
  assign axi_wready  = (state_q == WR_DATA);
  assign axi_bvalid  = (state_q == WR_RESP);
  assign axi_bid     = id_q;
  assign axi_bresp   = {err_q, 1'b0};
  assign axi_rvalid  = (state_q == RD_DATA);
  assign axi_rid     = id_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_mem_responder
//  Purpose  : Directed self-checking bench for axi_mem_responder with
//             hand-computed expected values (default build, no range check).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] axi_awid;
  logic [39:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [11:0] axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [11:0] axi_arid;
  logic [39:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [11:0] axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic aw(input logic [11:0] id, input logic [39:0] addr, input logic [7:0] len);
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awvalid = 1'b1;
    #1;
    for (int k = 0; k < 50 && !axi_awready; k++) cyc();
    if (!axi_awready) chk("aw_timeout", 64'd0, 64'd1);
    cyc();
    axi_awvalid = 1'b0;
  endtask

  task automatic wbeat(input logic [63:0] d, input logic [7:0] s, input logic last);
    axi_wdata = d; axi_wstrb = s; axi_wlast = last; axi_wvalid = 1'b1;
    #1;
    for (int k = 0; k < 50 && !axi_wready; k++) cyc();
    if (!axi_wready) chk("w_timeout", 64'd0, 64'd1);
    cyc();
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
  endtask

  task automatic bchk(input string tag, input logic [11:0] id, input logic [1:0] resp);
    axi_bready = 1'b1;
    #1;
    for (int k = 0; k < 50 && !axi_bvalid; k++) cyc();
    chk({tag, "_bid"}, 64'(axi_bid), 64'(id));
    chk({tag, "_bresp"}, 64'(axi_bresp), 64'(resp));
    cyc();
    axi_bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 64'(axi_bvalid), 64'd0);
  endtask

  task automatic ar(input logic [11:0] id, input logic [39:0] addr, input logic [7:0] len);
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arvalid = 1'b1;
    #1;
    for (int k = 0; k < 50 && !axi_arready; k++) cyc();
    if (!axi_arready) chk("ar_timeout", 64'd0, 64'd1);
    cyc();
    axi_arvalid = 1'b0;
  endtask

  // Checks the presented beat, then completes the R handshake.
  task automatic rbeat(input string tag, input logic [11:0] id, input logic [63:0] d,
                       input logic last);
    axi_rready = 1'b1;
    #1;
    chk({tag, "_rvalid"}, 64'(axi_rvalid), 64'd1);
    chk({tag, "_rdata"}, axi_rdata, d);
    chk({tag, "_rlast"}, 64'(axi_rlast), 64'(last));
    chk({tag, "_rresp"}, 64'(axi_rresp), 64'd0);
    chk({tag, "_rid"}, 64'(axi_rid), 64'(id));
    cyc();
    axi_rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0;
    axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0;
    axi_rready = 1'b0;

    // Reset state
    cyc(); cyc();
    axi_awvalid = 1'b1; axi_arvalid = 1'b1;
    #1;
    chk("rst_awready", 64'(axi_awready), 64'd0);
    chk("rst_arready", 64'(axi_arready), 64'd0);
    chk("rst_valids", 64'({axi_wready, axi_bvalid, axi_rvalid}), 64'd0);
    chk("rst_bid_bresp", 64'({axi_bid, axi_bresp}), 64'd0);
    chk("rst_rdata", axi_rdata, 64'd0);
    chk("rst_rid_rresp_rlast", 64'({axi_rid, axi_rresp, axi_rlast}), 64'd0);
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    rst = 1'b0;
    cyc();
    chk("idle_awready", 64'(axi_awready), 64'd1);
    chk("idle_arready", 64'(axi_arready), 64'd1);

    // Single-beat write then read (sub-word offset ignored on the read)
    aw(12'h123, 40'h100, 8'd0);
    wbeat(64'h1122334455667788, 8'hFF, 1'b1);
    chk("single_bvalid_lat", 64'(axi_bvalid), 64'd1);
    bchk("single", 12'h123, 2'b00);
    ar(12'h5A5, 40'h105, 8'd0);
    chk("single_rvalid_lat", 64'(axi_rvalid), 64'd1);
    rbeat("single_rd", 12'h5A5, 64'h1122334455667788, 1'b1);
    chk("single_rvalid_drop", 64'(axi_rvalid), 64'd0);

    // Burst write and read with rready toggling 1,0,1,0
    aw(12'h011, 40'h200, 8'd3);
    for (int i = 0; i < 4; i++) wbeat(64'hA0 + 64'(i), 8'hFF, i == 3);
    bchk("burst", 12'h011, 2'b00);
    ar(12'h022, 40'h200, 8'd3);
    rbeat("burst_b0", 12'h022, 64'hA0, 1'b0);
    chk("burst_stall1_data", axi_rdata, 64'hA1);
    cyc();
    chk("burst_stall1_hold", axi_rdata, 64'hA1);
    chk("burst_stall1_rvalid", 64'(axi_rvalid), 64'd1);
    rbeat("burst_b1", 12'h022, 64'hA1, 1'b0);
    cyc();
    chk("burst_stall2_hold", 64'({axi_rdata[7:0], axi_rlast}), 64'({8'hA2, 1'b0}));
    rbeat("burst_b2", 12'h022, 64'hA2, 1'b0);
    rbeat("burst_b3", 12'h022, 64'hA3, 1'b1);
    chk("burst_end_rvalid", 64'(axi_rvalid), 64'd0);

    // Partial strobe merge
    aw(12'h033, 40'h300, 8'd0);
    wbeat(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1);
    bchk("prefill", 12'h033, 2'b00);
    aw(12'h034, 40'h300, 8'd0);
    wbeat(64'h0, 8'h0F, 1'b1);
    bchk("strb", 12'h034, 2'b00);
    ar(12'h035, 40'h300, 8'd0);
    rbeat("strb_rd", 12'h035, 64'hFFFFFFFF00000000, 1'b1);

    // AW and AR together: write wins, read waits for the B handshake
    axi_awid = 12'h007; axi_awaddr = 40'h500; axi_awlen = 8'd0; axi_awvalid = 1'b1;
    axi_arid = 12'h009; axi_araddr = 40'h500; axi_arlen = 8'd0; axi_arvalid = 1'b1;
    #1;
    chk("coll_awready", 64'(axi_awready), 64'd1);
    chk("coll_arready", 64'(axi_arready), 64'd0);
    cyc();
    axi_awvalid = 1'b0;
    #1;
    chk("coll_wr_arready", 64'(axi_arready), 64'd0);
    wbeat(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
    chk("coll_resp_arready", 64'(axi_arready), 64'd0);
    bchk("coll", 12'h007, 2'b00);
    chk("coll_idle_arready", 64'(axi_arready), 64'd1);
    ar(12'h009, 40'h500, 8'd0);
    rbeat("coll_rd", 12'h009, 64'hDEADBEEFCAFEF00D, 1'b1);

    // Early wlast: burst still 4 beats, SLVERR, B held while bready=0
    aw(12'h0E1, 40'h600, 8'd3);
    wbeat(64'hB0, 8'hFF, 1'b0);
    wbeat(64'hB1, 8'hFF, 1'b1);
    chk("early_wlast_wready", 64'(axi_wready), 64'd1);
    wbeat(64'hB2, 8'hFF, 1'b0);
    wbeat(64'hB3, 8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("hold_bvalid", 64'(axi_bvalid), 64'd1);
      chk("hold_bid", 64'(axi_bid), 64'h0E1);
      cyc();
    end
    bchk("early", 12'h0E1, 2'b10);
    ar(12'h0E2, 40'h618, 8'd0);
    rbeat("early_rd_b3", 12'h0E2, 64'hB3, 1'b1);

    // Reset during beat 2 of an 8-beat read
    aw(12'h0C0, 40'h400, 8'd7);
    for (int i = 0; i < 8; i++) wbeat(64'hC0 + 64'(i), 8'hFF, i == 7);
    bchk("pre_rst", 12'h0C0, 2'b00);
    ar(12'h0C1, 40'h400, 8'd7);
    rbeat("mid_b0", 12'h0C1, 64'hC0, 1'b0);
    rbeat("mid_b1", 12'h0C1, 64'hC1, 1'b0);
    chk("mid_b2_rvalid", 64'(axi_rvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 64'(axi_rvalid), 64'd0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_idle", 64'({axi_awready, axi_arready, axi_bvalid, axi_rvalid}), 64'b1100);
    ar(12'h0C2, 40'h410, 8'd0);
    rbeat("post_rst_mem", 12'h0C2, 64'hC2, 1'b1);
    ar(12'h0C3, 40'h100, 8'd0);
    rbeat("post_rst_mem0", 12'h0C3, 64'h1122334455667788, 1'b1);

    // 256-beat write and read
    aw(12'hFFF, 40'h0, 8'd255);
    for (int i = 0; i < 256; i++) begin
      wbeat(64'h5500000000000000 | 64'(i), 8'hFF, i == 255);
      if (i == 254) chk("len255_wready", 64'(axi_wready), 64'd1);
    end
    bchk("len255", 12'hFFF, 2'b00);
    ar(12'hFFE, 40'h0, 8'd255);
    for (int i = 0; i < 256; i++)
      rbeat("len255_rd", 12'hFFE, 64'h5500000000000000 | 64'(i), i == 255);
    chk("len255_end", 64'(axi_rvalid), 64'd0);

    // Burst wraps across the top of memory (word 1023 -> word 0)
    aw(12'h0AA, 40'h1FF8, 8'd1);
    wbeat(64'h7777000000000001, 8'hFF, 1'b0);
    wbeat(64'h7777000000000002, 8'hFF, 1'b1);
    bchk("wrap", 12'h0AA, 2'b00);
    ar(12'h0AB, 40'h0, 8'd0);
    rbeat("wrap_w0", 12'h0AB, 64'h7777000000000002, 1'b1);
    ar(12'h0AC, 40'h1FF8, 8'd1);
    rbeat("wrap_rd0", 12'h0AC, 64'h7777000000000001, 1'b0);
    rbeat("wrap_rd1", 12'h0AC, 64'h7777000000000002, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
